// File: rtl/tx_frame_serializer_pkg.sv
// Shared types and helpers for the CADU frame serializer (tx_frame_serializer and tx_nrzm_enc).
package tx_pkg;

  typedef enum logic {TX_IDLE = 1'b0, TX_SHIFT = 1'b1} tx_state_e;

  localparam int unsigned SYM_BITS_BPSK = 1;
  localparam int unsigned SYM_BITS_QPSK = 2;
  localparam int unsigned SYM_BITS_QUAD = 4;

  function automatic int unsigned sym_count(input int unsigned w, input int unsigned sym_bits);
    return w / sym_bits;
  endfunction

  function automatic bit sym_bits_legal(input int unsigned sym_bits);
    return (sym_bits == SYM_BITS_BPSK) || (sym_bits == SYM_BITS_QPSK) || (sym_bits == SYM_BITS_QUAD);
  endfunction

endpackage

// File: rtl/tx_frame_serializer_nrzm_enc.sv
// NRZ-M differential encoder, one independent lane per symbol bit; used only when TX_SER_NRZM_EN is defined.
module tx_nrzm_enc #(
  parameter int unsigned SYM_BITS = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clr_i,
  input  logic                stb_i,
  input  logic [SYM_BITS-1:0] sym_i,
  output logic [SYM_BITS-1:0] sym_o
);

  logic [SYM_BITS-1:0] lane_r;

  // Encoded value the next symbol will take; the caller only uses it on a strobe.
  assign sym_o = lane_r ^ sym_i;

  // Lane state: toggles per '1' bit on each strobe, cleared whenever the serializer idles.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lane_r <= {SYM_BITS{1'b0}};
    end else if (clr_i) begin
      lane_r <= {SYM_BITS{1'b0}};
    end else if (stb_i) begin
      lane_r <= lane_r ^ sym_i;
    end else begin
      lane_r <= lane_r;
    end
  end

endmodule

// File: rtl/tx_frame_serializer.sv
// Frame-in, symbol-out CADU serializer with a shadow buffer for gapless back-to-back frames.
// Optional NRZ-M line coding is enabled by defining TX_SER_NRZM_EN.
module tx_frame_serializer
  import tx_pkg::*;
#(
  parameter int unsigned FRAME_BYTES = 20,
  parameter int unsigned SYM_BITS    = 1,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [FRAME_BYTES*8-1:0] data_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic [CNT_W-1:0]         cycles_per_sym_i,
  output logic [SYM_BITS-1:0]      data_o,
  output logic                     valid_o,
  output logic                     sym_stb_o,
  output logic                     sof_o,
  output logic                     eof_o
);

  localparam int unsigned W     = FRAME_BYTES * 8;
  localparam int unsigned NSYM  = sym_count(W, SYM_BITS);
  localparam int unsigned IDX_W = (NSYM > 1) ? $clog2(NSYM) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSYM - 1);

  if (!sym_bits_legal(SYM_BITS) || ((W % SYM_BITS) != 0)) begin : g_bad_cfg
    $error("tx_frame_serializer: SYM_BITS must be 1, 2 or 4 and divide the frame width");
  end

  tx_state_e           state_r, state_s;
  logic [W-1:0]        active_r, active_s, shadow_r, shadow_s;
  logic                shadow_full_r, shadow_full_s;
  logic [CNT_W-1:0]    hold_r, hold_s, cnt_r, cnt_s;
  logic [IDX_W-1:0]    idx_r, idx_s;
  logic                valid_s, stb_s, sof_s, eof_s;
  logic [SYM_BITS-1:0] sym_s, enc_sym_s, data_s;
  logic                xfer_s, sym_end_s, frame_end_s, load_s;

  assign xfer_s        = valid_i & ready_o;
  assign sym_end_s     = (state_r == TX_SHIFT) && (cnt_r == (hold_r - CNT_W'(1)));
  assign frame_end_s   = sym_end_s && (idx_r == LAST_IDX);
  assign load_s        = shadow_full_r && ((state_r == TX_IDLE) || frame_end_s);
  assign shadow_full_s = (shadow_full_r & ~load_s) | xfer_s;
  assign shadow_s      = xfer_s ? data_i : shadow_r;
  // data_o only changes on a symbol boundary or when the line goes idle.
  assign data_s        = stb_s ? enc_sym_s : (valid_s ? data_o : {SYM_BITS{1'b0}});

  // Next-state and next-output decode; a load takes priority so frames chain without a gap.
  always_comb begin
    state_s  = state_r;
    active_s = active_r;
    hold_s   = hold_r;
    cnt_s    = cnt_r;
    idx_s    = idx_r;
    valid_s  = valid_o;
    stb_s    = 1'b0;
    sof_s    = 1'b0;
    eof_s    = eof_o;
    sym_s    = {SYM_BITS{1'b0}};
    if (load_s) begin
      state_s  = TX_SHIFT;
      active_s = shadow_r << SYM_BITS;
      hold_s   = (cycles_per_sym_i == {CNT_W{1'b0}}) ? CNT_W'(1) : cycles_per_sym_i;
      cnt_s    = {CNT_W{1'b0}};
      idx_s    = {IDX_W{1'b0}};
      valid_s  = 1'b1;
      stb_s    = 1'b1;
      sof_s    = 1'b1;
      sym_s    = shadow_r[W-1 -: SYM_BITS];
      eof_s    = (LAST_IDX == {IDX_W{1'b0}});
    end else begin
      case (state_r)
        TX_IDLE: begin
          valid_s = 1'b0;
          eof_s   = 1'b0;
        end
        TX_SHIFT: begin
          if (frame_end_s) begin
            state_s = TX_IDLE;
            valid_s = 1'b0;
            eof_s   = 1'b0;
            cnt_s   = {CNT_W{1'b0}};
            idx_s   = {IDX_W{1'b0}};
          end else if (sym_end_s) begin
            cnt_s    = {CNT_W{1'b0}};
            idx_s    = idx_r + IDX_W'(1);
            stb_s    = 1'b1;
            sym_s    = active_r[W-1 -: SYM_BITS];
            active_s = active_r << SYM_BITS;
            eof_s    = (idx_s == LAST_IDX);
          end else begin
            cnt_s = cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_s = TX_IDLE;
          valid_s = 1'b0;
          eof_s   = 1'b0;
        end
      endcase
    end
  end

`ifdef TX_SER_NRZM_EN
  logic clr_s;
  assign clr_s = (state_s == TX_IDLE);

  tx_nrzm_enc #(.SYM_BITS(SYM_BITS)) u_nrzm (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (clr_s),
    .stb_i (stb_s),
    .sym_i (sym_s),
    .sym_o (enc_sym_s)
  );
`else
  assign enc_sym_s = sym_s;
`endif

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= TX_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Frame buffers, symbol timing and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      active_r      <= {W{1'b0}};
      shadow_r      <= {W{1'b0}};
      shadow_full_r <= 1'b0;
      hold_r        <= CNT_W'(1);
      cnt_r         <= {CNT_W{1'b0}};
      idx_r         <= {IDX_W{1'b0}};
      data_o        <= {SYM_BITS{1'b0}};
      valid_o       <= 1'b0;
      sym_stb_o     <= 1'b0;
      sof_o         <= 1'b0;
      eof_o         <= 1'b0;
      ready_o       <= 1'b1;
    end else begin
      active_r      <= active_s;
      shadow_r      <= shadow_s;
      shadow_full_r <= shadow_full_s;
      hold_r        <= hold_s;
      cnt_r         <= cnt_s;
      idx_r         <= idx_s;
      data_o        <= data_s;
      valid_o       <= valid_s;
      sym_stb_o     <= stb_s;
      sof_o         <= sof_s;
      eof_o         <= eof_s;
      ready_o       <= ~shadow_full_s;
    end
  end

endmodule

// File: tb/tb_tx_frame_serializer.sv
// Self-checking bench for tx_frame_serializer: instance A (2-byte frames, 1-bit symbols), instance B (1-byte, 2-bit).
module tb_tx_frame_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [15:0] a_data;
  logic        a_valid, a_ready, a_vo, a_stb, a_sof, a_eof;
  logic [31:0] a_cps;
  logic [0:0]  a_dout;
  logic [7:0]  b_data;
  logic        b_valid, b_ready, b_vo, b_stb, b_sof, b_eof;
  logic [31:0] b_cps;
  logic [1:0]  b_dout;

  tx_frame_serializer #(.FRAME_BYTES(2), .SYM_BITS(1), .CNT_W(32)) u_a (
    .clk_i(clk), .rst_i(rst), .data_i(a_data), .valid_i(a_valid), .ready_o(a_ready),
    .cycles_per_sym_i(a_cps), .data_o(a_dout), .valid_o(a_vo), .sym_stb_o(a_stb),
    .sof_o(a_sof), .eof_o(a_eof)
  );

  tx_frame_serializer #(.FRAME_BYTES(1), .SYM_BITS(2), .CNT_W(32)) u_b (
    .clk_i(clk), .rst_i(rst), .data_i(b_data), .valid_i(b_valid), .ready_o(b_ready),
    .cycles_per_sym_i(b_cps), .data_o(b_dout), .valid_o(b_vo), .sym_stb_o(b_stb),
    .sof_o(b_sof), .eof_o(b_eof)
  );

  typedef struct packed {
    logic [3:0] d;
    logic       sof;
    logic       eof;
    logic       stb;
  } cyc_t;

  typedef struct {
    logic [15:0] data;
    int          cps;
    int          exp_valid;
    int          exp_stb;
    int          exp_eof;
  } vec_t;

  cyc_t        cap_a[$], cap_b[$], exp_q[$];
  int          cyc_a[$], cyc_b[$];
  int          cyc_cnt = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  int          last_xfer = 0;
  logic [15:0] m_fr[3];
  int          m_cp[3];

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  always @(negedge clk) begin
    if (a_vo === 1'b1) begin
      cap_a.push_back(cyc_t'{d: {3'b000, a_dout}, sof: a_sof, eof: a_eof, stb: a_stb});
      cyc_a.push_back(cyc_cnt);
    end
    if (b_vo === 1'b1) begin
      cap_b.push_back(cyc_t'{d: {2'b00, b_dout}, sof: b_sof, eof: b_eof, stb: b_stb});
      cyc_b.push_back(cyc_cnt);
    end
  end

  task automatic chk(input string nm, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  task automatic clr_cap();
    cap_a.delete(); cyc_a.delete();
    cap_b.delete(); cyc_b.delete();
  endtask

  // Expected output stream: each frame's symbols MSB-first, each held max(cps,1) cycles, frames back to back.
  task automatic build_exp(input int n, input int w, input int s);
    int lane;
    int sym;
    int out;
    int hold;
    exp_q.delete();
    lane = 0;
    for (int f = 0; f < n; f++) begin
      hold = (m_cp[f] == 0) ? 1 : m_cp[f];
      for (int k = 0; k < w / s; k++) begin
        sym = (int'(m_fr[f]) >> (w - (k + 1) * s)) & ((1 << s) - 1);
`ifdef TX_SER_NRZM_EN
        lane = lane ^ sym;
        out  = lane;
`else
        out  = sym;
`endif
        for (int j = 0; j < hold; j++)
          exp_q.push_back(cyc_t'{d: 4'(out), sof: (k == 0 && j == 0), eof: (k == w / s - 1), stb: (j == 0)});
      end
    end
  endtask

  task automatic cmp_stream(input string nm, input int sel);
    cyc_t got[$];
    int   cy[$];
    int   n;
    if (sel == 0) begin got = cap_a; cy = cyc_a; end
    else          begin got = cap_b; cy = cyc_b; end
    chk({nm, "_len"}, got.size(), exp_q.size());
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({nm, "_cyc"}, got[i], exp_q[i]);
    if (got.size() > 0) chk({nm, "_nogap"}, cy[cy.size()-1] - cy[0] + 1, got.size());
  endtask

  task automatic push(input int sel, input logic [15:0] d);
    int   t;
    logic rdy;
    t = 0;
    if (sel == 0) begin a_data = d; a_valid = 1'b1; end
    else          begin b_data = d[7:0]; b_valid = 1'b1; end
    rdy = (sel == 0) ? a_ready : b_ready;
    while (rdy !== 1'b1 && t < 300) begin
      @(posedge clk); #1;
      t++;
      rdy = (sel == 0) ? a_ready : b_ready;
    end
    chk("push_ready", rdy, 1);
    last_xfer = cyc_cnt;
    @(posedge clk); #1;
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  vec_t       tbl[4];
  logic [1:0] hand_b[4];
  int         n_stb, n_eof, n_sof, t, nf, cps_r, tot;

  initial begin
    tbl[0] = '{data: 16'hA5C3, cps: 3, exp_valid: 48, exp_stb: 16, exp_eof: 3};
    tbl[1] = '{data: 16'h0FF0, cps: 1, exp_valid: 16, exp_stb: 16, exp_eof: 1};
    tbl[2] = '{data: 16'hFFFF, cps: 0, exp_valid: 16, exp_stb: 16, exp_eof: 1};
    tbl[3] = '{data: 16'h8001, cps: 2, exp_valid: 32, exp_stb: 16, exp_eof: 2};
`ifdef TX_SER_NRZM_EN
    hand_b = '{2'd2, 2'd1, 2'd0, 2'd0};
`else
    hand_b = '{2'd2, 2'd3, 2'd1, 2'd0};
`endif

    rst = 1'b1;
    a_data = 16'h0; a_valid = 1'b0; a_cps = 32'd1;
    b_data = 8'h0;  b_valid = 1'b0; b_cps = 32'd1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_a_data", a_dout, 0);
    chk("rst_a_valid", a_vo, 0);
    chk("rst_a_stb", a_stb, 0);
    chk("rst_a_sof", a_sof, 0);
    chk("rst_a_eof", a_eof, 0);
    chk("rst_a_ready", a_ready, 1);
    chk("rst_b_ready", b_ready, 1);
    chk("rst_b_valid", b_vo, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    run(2);

    // Single frames from the vector table.
    for (int i = 0; i < 4; i++) begin
      clr_cap();
      a_cps = tbl[i].cps;
      push(0, tbl[i].data);
      run(tbl[i].exp_valid + 8);
      n_stb = 0; n_eof = 0; n_sof = 0;
      foreach (cap_a[j]) begin
        n_stb += int'(cap_a[j].stb);
        n_eof += int'(cap_a[j].eof);
        n_sof += int'(cap_a[j].sof);
      end
      chk("tbl_valid_cycles", cap_a.size(), tbl[i].exp_valid);
      chk("tbl_stb_count", n_stb, tbl[i].exp_stb);
      chk("tbl_eof_cycles", n_eof, tbl[i].exp_eof);
      chk("tbl_sof_count", n_sof, 1);
      chk("tbl_latency", (cap_a.size() > 0) ? (cyc_a[0] - last_xfer) : -1, 2);
      m_fr[0] = tbl[i].data; m_cp[0] = tbl[i].cps;
      build_exp(1, 16, 1);
      cmp_stream("tbl_stream", 0);
    end

    // Back-to-back frames: second offered while the first shifts.
    clr_cap();
    a_cps = 3;
    push(0, 16'hA5C3);
    push(0, 16'h0FF0);
    chk("b2b_ready_low", a_ready, 0);
    run(96 + 10);
    m_fr[0] = 16'hA5C3; m_cp[0] = 3;
    m_fr[1] = 16'h0FF0; m_cp[1] = 3;
    build_exp(2, 16, 1);
    cmp_stream("b2b", 0);
    chk("b2b_ready_after", a_ready, 1);

    // Hold length changed mid-frame applies only to the next frame.
    clr_cap();
    a_cps = 3;
    push(0, 16'h3C5A);
    push(0, 16'hC3A5);
    a_cps = 5;
    run(48 + 80 + 10);
    m_fr[0] = 16'h3C5A; m_cp[0] = 3;
    m_fr[1] = 16'hC3A5; m_cp[1] = 5;
    build_exp(2, 16, 1);
    cmp_stream("cps_change", 0);

    // Reset at symbol 7 of frame 1 with frame 2 waiting in the shadow buffer.
    clr_cap();
    a_cps = 1;
    push(0, 16'hA5C3);
    push(0, 16'h0FF0);
    t = 0;
    while (cap_a.size() < 8 && t < 100) begin
      @(negedge clk); #1;
      t++;
    end
    chk("rst_reach_sym7", cap_a.size(), 8);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_valid", a_vo, 0);
    chk("midrst_ready", a_ready, 1);
    chk("midrst_data", a_dout, 0);
    chk("midrst_eof", a_eof, 0);
    @(posedge clk); #1;
    run(40);
    chk("midrst_frame2_dropped", cap_a.size(), 8);

    // Randomized gapless groups against the reference stream.
    for (int it = 0; it < 6; it++) begin
      clr_cap();
      nf    = 1 + int'($urandom % 3);
      cps_r = int'($urandom % 4);
      a_cps = cps_r;
      for (int f = 0; f < nf; f++) begin
        m_fr[f] = 16'($urandom);
        m_cp[f] = cps_r;
      end
      for (int f = 0; f < nf; f++) push(0, m_fr[f]);
      tot = nf * 16 * ((cps_r == 0) ? 1 : cps_r);
      run(tot + 10);
      build_exp(nf, 16, 1);
      cmp_stream("rand", 0);
    end

    // Two-bit symbols, one cycle each.
    clr_cap();
    b_cps = 1;
    push(1, 16'h00B4);
    run(12);
    chk("b_len", cap_b.size(), 4);
    for (int i = 0; i < 4; i++) chk("b_sym", (cap_b.size() > i) ? cap_b[i].d : 4'hF, hand_b[i]);
    m_fr[0] = 16'h00B4; m_cp[0] = 1;
    build_exp(1, 8, 2);
    cmp_stream("b_b4", 1);

    // Same frame twice with an idle gap: lane state must restart from zero.
    for (int r = 0; r < 2; r++) begin
      clr_cap();
      b_cps = 2;
      push(1, 16'h00F0);
      run(16);
      m_fr[0] = 16'h00F0; m_cp[0] = 2;
      build_exp(1, 8, 2);
      cmp_stream("b_f0", 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
